feed_arbiter: RTL and testbench
===============================

FEED_ARBITER -- requirements
Module: feed_arbiter

Interface
REQ-001 SHALL have parameter C_PKT_BEAT_BYTES, default 8, bytes per Avalon-ST beat.
REQ-002 SHALL have parameter C_WDOG_CYCLES, default 1024, watchdog stall limit in cycles.
REQ-003 SHALL derive W=C_PKT_BEAT_BYTES*8 and E=$clog2(C_PKT_BEAT_BYTES); these are not instantiation parameters.
REQ-004 Port clk  input  1  sole clock, all logic on rising edge.
REQ-005 Port reset_n  input  1  asynchronous, active-low reset.
REQ-006 Port in_ready  output  2  per-feed ready, bit i = feed i.
REQ-007 Port in_valid, in_startofpacket, in_endofpacket, in_error  input  2 each  per-feed Avalon-ST controls.
REQ-008 Port in_data  input  2*W  feed i occupies bits [i*W+:W].
REQ-009 Port in_empty  input  2*E  feed i occupies bits [i*E+:E].
REQ-010 Port out_ready  input  1  downstream ready.
REQ-011 Port out_valid, out_startofpacket, out_endofpacket, out_error  output  1 each  merged stream controls.
REQ-012 Port out_data  output  W, and out_empty  output  E  merged stream payload.
REQ-013 Port grant  output  2  one-hot feed currently owning the output, 0 when none.
REQ-014 Port drop_pulse  output  1  one-cycle pulse per discarded beat.
REQ-015 Port wdog_abort  output  1  one-cycle pulse when the watchdog terminates a packet.

Function
REQ-016 SHALL merge two decoded-message streams onto one output, packet-atomic: beats from different feeds are never interleaved within one out packet.
REQ-017 SHALL implement states IDLE, PASS and FLUSH; FLUSH is reachable only via the watchdog.
REQ-018 IDLE: among feeds with in_valid=1 and in_startofpacket=1, SHALL select one by round-robin, register grant and enter PASS next cycle; in_ready for such sop beats SHALL be 0 in IDLE.
REQ-019 Round-robin: the feed not granted most recently wins a tie; after reset feed 0 wins the first tie.
REQ-020 IDLE: a valid beat with in_startofpacket=0 SHALL be accepted (in_ready=1), discarded, and pulse drop_pulse the next cycle.
REQ-021 PASS: in_ready[g] SHALL equal (out_ready | ~out_valid) for granted feed g; the other feed's in_ready SHALL be 0.
REQ-022 Output stage SHALL be one register: an accepted beat appears on out_* the next cycle with data, empty, sop, eop and error copied unchanged.
REQ-023 out_valid SHALL hold with stable payload while out_ready=0.
REQ-024 On acceptance of the granted feed's eop beat SHALL return to IDLE next cycle and clear grant; first sop to out_valid latency is 2 cycles.
REQ-025 A beat with in_startofpacket=1 accepted in PASS after the first beat SHALL be forwarded with out_error=1.
REQ-026 Back-to-back packets: an eop beat and the next sop of either feed SHALL be separated by exactly one IDLE cycle.

Reset
REQ-027 While reset_n=0: in_ready=0, out_valid=0, all out_* payload 0, grant=0, drop_pulse=0, wdog_abort=0, state IDLE, round-robin pointer favouring feed 0.
REQ-028 Reset asserted mid-packet SHALL discard the packet immediately without emitting eop; after release operation restarts from IDLE.

Configuration
REQ-029 Macro FEED_ARBITER_WDOG_EN SHALL compile in the watchdog.
REQ-030 With FEED_ARBITER_WDOG_EN: in PASS a counter SHALL increment each cycle in_valid[g]=0 and clear on each accepted beat; on reaching C_WDOG_CYCLES the block SHALL emit one beat with out_valid=1, out_endofpacket=1, out_error=1, out_data=0, out_empty=C_PKT_BEAT_BYTES-1, pulse wdog_abort, and enter FLUSH.
REQ-031 FLUSH: in_ready[g]=1; beats of feed g discarded with drop_pulse; on its eop beat return to IDLE.
REQ-032 Without FEED_ARBITER_WDOG_EN: no counter, FLUSH never entered, wdog_abort tied 0, a stalled feed holds grant indefinitely.

Verification
REQ-033 Both feeds present 3-beat packets with sop in the same cycle after reset -> feed 0 output first, feed 1 second, no interleave, grant 01 then 10.
REQ-034 Feed 0 sends a 4-beat packet, out_ready low for cycles 2-4 -> out_valid held, payload stable, all 4 beats delivered in order, in_ready[0]=0 while stalled.
REQ-035 Feed 1 sends 2 beats without sop in IDLE -> both accepted, two drop_pulse, out_valid stays 0.
REQ-036 With FEED_ARBITER_WDOG_EN and C_WDOG_CYCLES=16, feed 0 stops after beat 1 of 3 -> after 16 idle cycles an eop+error beat with data 0 and empty 7, wdog_abort pulse, remaining feed 0 beats dropped.
REQ-037 reset_n low during beat 2 of a 5-beat packet -> out_valid=0 and grant=0 immediately; next packet after release passes intact.

Source files
------------

// File: rtl/feed_arbiter_if.sv
// Stream bundle for feed_arbiter: two Avalon-ST feeds in, one merged Avalon-ST stream out,
// plus grant/drop/watchdog status. slave = arbiter side, master = environment side.
interface feed_arbiter_if #(
   parameter int C_PKT_BEAT_BYTES = 8
);
   localparam int W = C_PKT_BEAT_BYTES * 8;
   localparam int E = $clog2(C_PKT_BEAT_BYTES);

   logic [1:0]     in_ready;
   logic [1:0]     in_valid;
   logic [1:0]     in_startofpacket;
   logic [1:0]     in_endofpacket;
   logic [1:0]     in_error;
   logic [2*W-1:0] in_data;
   logic [2*E-1:0] in_empty;

   logic           out_ready;
   logic           out_valid;
   logic           out_startofpacket;
   logic           out_endofpacket;
   logic           out_error;
   logic [W-1:0]   out_data;
   logic [E-1:0]   out_empty;

   logic [1:0]     grant;
   logic           drop_pulse;
   logic           wdog_abort;

   modport slave (
      input  in_valid, in_startofpacket, in_endofpacket, in_error, in_data, in_empty, out_ready,
      output in_ready, out_valid, out_startofpacket, out_endofpacket, out_error, out_data,
             out_empty, grant, drop_pulse, wdog_abort
   );

   modport master (
      output in_valid, in_startofpacket, in_endofpacket, in_error, in_data, in_empty, out_ready,
      input  in_ready, out_valid, out_startofpacket, out_endofpacket, out_error, out_data,
             out_empty, grant, drop_pulse, wdog_abort
   );
endinterface

// File: rtl/feed_arbiter.sv
// Packet-atomic round-robin merge of two Avalon-ST feeds through a single output register.
// Define FEED_ARBITER_WDOG_EN to compile in the stall watchdog that aborts a hung packet.
module feed_arbiter #(
   parameter int C_PKT_BEAT_BYTES = 8,
   parameter int C_WDOG_CYCLES    = 1024
) (
   input logic           clk,
   input logic           reset_n,
   feed_arbiter_if.slave bus
);
   localparam int W = C_PKT_BEAT_BYTES * 8;
   localparam int E = $clog2(C_PKT_BEAT_BYTES);

   typedef enum logic [1:0] {S_IDLE, S_PASS, S_FLUSH} state_e;

   typedef struct packed {
      logic [W-1:0] data;
      logic [E-1:0] empty;
      logic         sop;
      logic         eop;
      logic         err;
   } beat_t;

   state_e     state_q, state_d;
   logic [1:0] grant_q, grant_d;
   logic       last_q, last_d;     // index of the feed granted most recently
   logic       first_q, first_d;
   logic       out_valid_q, out_valid_d;
   beat_t      out_q, out_d;
   logic       drop_q, drop_d;
   logic       wdog_q, wdog_d;

   beat_t      g_beat;
   logic       g_valid;
   logic       can_take;
   logic       accept;
   logic       win;
   logic       wdog_fire;
   logic [1:0] sop_req;
   logic [1:0] ready;

   always_comb begin : granted_feed
      g_valid      = grant_q[1] ? bus.in_valid[1]         : bus.in_valid[0];
      g_beat.data  = grant_q[1] ? bus.in_data[2*W-1:W]    : bus.in_data[W-1:0];
      g_beat.empty = grant_q[1] ? bus.in_empty[2*E-1:E]   : bus.in_empty[E-1:0];
      g_beat.sop   = grant_q[1] ? bus.in_startofpacket[1] : bus.in_startofpacket[0];
      g_beat.eop   = grant_q[1] ? bus.in_endofpacket[1]   : bus.in_endofpacket[0];
      g_beat.err   = grant_q[1] ? bus.in_error[1]         : bus.in_error[0];
   end

   assign can_take = bus.out_ready | ~out_valid_q;
   assign sop_req  = bus.in_valid & bus.in_startofpacket;
   assign win      = (sop_req == 2'b11) ? ~last_q : sop_req[1];
   assign accept   = |(bus.in_valid & ready);

   // Output process: sop beats wait in IDLE while arbitration registers the grant.
   always_comb begin : ready_out
      // NOTE: every combinational output gets a default first, so no latch is inferred.
      ready = 2'b00;
      case (state_q)
         S_IDLE:  ready = bus.in_valid & ~bus.in_startofpacket;
         S_PASS:  ready = grant_q & {2{can_take}};
         S_FLUSH: ready = grant_q;
         default: ready = 2'b00;
      endcase
      if (!reset_n) ready = 2'b00;
   end

`ifdef FEED_ARBITER_WDOG_EN
   localparam int CW = $clog2(C_WDOG_CYCLES + 1);

   logic [CW-1:0] wdog_cnt_q, wdog_cnt_d;

   // Saturates at the limit until the output register can take the abort beat.
   always_comb begin : wdog_next
      wdog_cnt_d = wdog_cnt_q;
      wdog_fire  = 1'b0;
      if (state_q != S_PASS || accept) begin
         wdog_cnt_d = '0;
      end else if (!g_valid) begin
         if (wdog_cnt_q >= CW'(C_WDOG_CYCLES - 1)) begin
            if (can_take) begin
               wdog_fire  = 1'b1;
               wdog_cnt_d = '0;
            end
         end else begin
            wdog_cnt_d = wdog_cnt_q + 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) wdog_cnt_q <= '0;
      else          wdog_cnt_q <= wdog_cnt_d;
   end
`else
   assign wdog_fire = 1'b0;
`endif

   always_comb begin : next_state
      state_d     = state_q;
      grant_d     = grant_q;
      last_d      = last_q;
      first_d     = first_q;
      out_valid_d = out_valid_q & ~bus.out_ready;
      out_d       = out_q;
      drop_d      = 1'b0;
      wdog_d      = 1'b0;
      case (state_q)
         S_IDLE: begin
            drop_d = accept;
            if (|sop_req) begin
               grant_d = win ? 2'b10 : 2'b01;
               last_d  = win;
               first_d = 1'b1;
               state_d = S_PASS;
            end
         end
         S_PASS: begin
            if (accept) begin
               out_valid_d = 1'b1;
               out_d       = g_beat;
               out_d.err   = g_beat.err | (g_beat.sop & ~first_q);
               first_d     = 1'b0;
               if (g_beat.eop) begin
                  state_d = S_IDLE;
                  grant_d = 2'b00;
               end
            end else if (wdog_fire) begin
               out_valid_d = 1'b1;
               out_d       = '{data: '0, empty: E'(C_PKT_BEAT_BYTES - 1), sop: 1'b0, eop: 1'b1, err: 1'b1};
               wdog_d      = 1'b1;
               state_d     = S_FLUSH;
            end
         end
         S_FLUSH: begin
            drop_d = accept;
            if (accept && g_beat.eop) begin
               state_d = S_IDLE;
               grant_d = 2'b00;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q     <= S_IDLE;
         grant_q     <= 2'b00;
         last_q      <= 1'b1;
         first_q     <= 1'b0;
         out_valid_q <= 1'b0;
         out_q       <= '0;
         drop_q      <= 1'b0;
         wdog_q      <= 1'b0;
      end else begin
         // NOTE: non-blocking assignments so every flop samples pre-edge values.
         state_q     <= state_d;
         grant_q     <= grant_d;
         last_q      <= last_d;
         first_q     <= first_d;
         out_valid_q <= out_valid_d;
         out_q       <= out_d;
         drop_q      <= drop_d;
         wdog_q      <= wdog_d;
      end
   end

   assign bus.in_ready          = ready;
   assign bus.out_valid         = out_valid_q;
   assign bus.out_data          = out_q.data;
   assign bus.out_empty         = out_q.empty;
   assign bus.out_startofpacket = out_q.sop;
   assign bus.out_endofpacket   = out_q.eop;
   assign bus.out_error         = out_q.err;
   assign bus.grant             = grant_q;
   assign bus.drop_pulse        = drop_q;
   assign bus.wdog_abort        = wdog_q;
endmodule

// File: tb/tb_feed_arbiter.sv
// Self-checking bench for feed_arbiter: vector tables plus scoreboarded packet sequences.
module tb_feed_arbiter;
   localparam int BB = 8;
   localparam int W  = BB * 8;
   localparam int E  = $clog2(BB);
   localparam int WD = 16;

   typedef struct packed {
      logic [W-1:0] data;
      logic [E-1:0] empty;
      logic         sop;
      logic         eop;
      logic         err;
   } beat_t;

   typedef struct {
      logic [1:0] valid;
      logic [1:0] sop;
      logic [1:0] exp_ready;
   } idle_vec_t;

   typedef struct {
      logic [1:0] req;
      logic [1:0] exp_grant;
   } rr_vec_t;

   logic clk = 1'b0;
   logic reset_n = 1'b1;

   feed_arbiter_if #(.C_PKT_BEAT_BYTES(BB)) bus ();

   feed_arbiter #(.C_PKT_BEAT_BYTES(BB), .C_WDOG_CYCLES(WD)) dut (
      .clk     (clk),
      .reset_n (reset_n),
      .bus     (bus)
   );

   always #5 clk = ~clk;

   int         total = 0;
   int         bad = 0;
   beat_t      exp_q[$];
   logic [1:0] grant_hist[$];
   logic [1:0] last_g = 2'b00;
   int         cyc = 0;
   int         drop_cnt = 0, wdog_cnt = 0, ov_cnt = 0;
   int         wdog_cyc = -1, first_ov_cyc = -1, eop0_cyc = -1, sop1_cyc = -1;
   logic [1:0] samp_acc, samp_ready, samp_grant;
   logic       samp_ov;
   beat_t      held;
   logic       held_v = 1'b0;

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic beat_t out_beat();
      return beat_t'({bus.out_data, bus.out_empty, bus.out_startofpacket,
                      bus.out_endofpacket, bus.out_error});
   endfunction

   // One clock: sample/score at the falling edge, return 1 time unit after the rising edge.
   task automatic tick();
      beat_t cur, e;
      @(negedge clk);
      cyc++;
      samp_acc   = bus.in_valid & bus.in_ready;
      samp_ready = bus.in_ready;
      samp_grant = bus.grant;
      samp_ov    = bus.out_valid;
      if (samp_grant != 2'b00 && samp_grant != last_g) grant_hist.push_back(samp_grant);
      last_g = samp_grant;
      if (reset_n) begin
         cur = out_beat();
         if (held_v) check("hold_payload", {cur, bus.out_valid}, {held, 1'b1});
         held_v = bus.out_valid & ~bus.out_ready;
         held   = cur;
         if (bus.out_valid && first_ov_cyc < 0) first_ov_cyc = cyc;
         ov_cnt   += int'(bus.out_valid);
         drop_cnt += int'(bus.drop_pulse);
         if (bus.wdog_abort) begin
            wdog_cnt++;
            wdog_cyc = cyc;
         end
         if (bus.out_valid && bus.out_ready) begin
            if (exp_q.size() == 0) begin
               total++;
               bad++;
               $display("FAIL unexpected_beat: got %0h expected none", cur);
            end else begin
               e = exp_q.pop_front();
               check("out_beat", cur, e);
            end
         end
      end else begin
         held_v = 1'b0;
      end
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input int f, input logic v, input logic sop, input logic eop,
                        input logic err, input logic [W-1:0] d, input logic [E-1:0] em);
      bus.in_valid[f]            = v;
      bus.in_startofpacket[f]    = sop;
      bus.in_endofpacket[f]      = eop;
      bus.in_error[f]            = err;
      bus.in_data[f*W +: W]      = d;
      bus.in_empty[f*E +: E]     = em;
   endtask

   // Reference: what the output stream must carry for one packet.
   task automatic push_pkt(input int n, input logic [W-1:0] base, input int bad_sop, input int err_beat);
      beat_t e;
      for (int k = 0; k < n; k++) begin
         e.data  = base + W'(k);
         e.empty = E'(k);
         e.sop   = (k == 0) || (k == bad_sop);
         e.eop   = (k == n - 1);
         e.err   = (k == err_beat) || (k == bad_sop && k != 0);
         exp_q.push_back(e);
      end
   endtask

   // Presents up to two packets concurrently; out_ready is low for iterations stall_lo..stall_hi.
   task automatic run_feeds(input int n0, input int n1, input logic [W-1:0] b0, input logic [W-1:0] b1,
                            input int stall_lo, input int stall_hi, input int bad_sop, input int err_beat);
      int k[2];
      int n[2];
      logic [W-1:0] b[2];
      int t;
      n = '{n0, n1};
      b = '{b0, b1};
      k = '{0, 0};
      t = 0;
      eop0_cyc = -1;
      sop1_cyc = -1;
      while ((k[0] < n[0] || k[1] < n[1]) && t < 200) begin
         bus.out_ready = !(t >= stall_lo && t <= stall_hi);
         for (int f = 0; f < 2; f++) begin
            if (k[f] < n[f])
               drive(f, 1'b1, (k[f] == 0) || (f == 0 && k[f] == bad_sop), k[f] == n[f] - 1,
                     f == 0 && k[f] == err_beat, b[f] + W'(k[f]), E'(k[f]));
            else
               drive(f, 1'b0, 1'b0, 1'b0, 1'b0, '0, '0);
         end
         tick();
         if (!bus.out_ready && samp_ov) check("stall_in_ready", samp_ready, 2'b00);
         for (int f = 0; f < 2; f++) begin
            if (samp_acc[f]) begin
               if (f == 0 && k[0] == n[0] - 1) eop0_cyc = cyc;
               if (f == 1 && k[1] == 0) sop1_cyc = cyc;
               k[f]++;
            end
         end
         t++;
      end
      drive(0, 1'b0, 1'b0, 1'b0, 1'b0, '0, '0);
      drive(1, 1'b0, 1'b0, 1'b0, 1'b0, '0, '0);
      bus.out_ready = 1'b1;
      check("feeds_done_in_budget", 128'(t < 200), 128'(1));
   endtask

   task automatic send_one(input int f, input logic sop, input logic eop, input logic [W-1:0] d,
                           input logic [E-1:0] em);
      logic got;
      got = 1'b0;
      drive(f, 1'b1, sop, eop, 1'b0, d, em);
      for (int i = 0; i < 20 && !got; i++) begin
         tick();
         got = samp_acc[f];
      end
      check("beat_accepted", 128'(got), 128'(1));
   endtask

   task automatic drain();
      for (int i = 0; i < 20 && (exp_q.size() != 0 || bus.out_valid); i++) tick();
      check("scoreboard_empty", 128'(exp_q.size()), 128'(0));
   endtask

   initial begin
      idle_vec_t iv[7];
      rr_vec_t   rv[6];
      int        mark, d0, o0, w0, acc_cyc;
      logic      got;
      beat_t     ab;

      iv = '{'{2'b00, 2'b00, 2'b00}, '{2'b01, 2'b00, 2'b01}, '{2'b10, 2'b00, 2'b10},
             '{2'b11, 2'b00, 2'b11}, '{2'b11, 2'b11, 2'b00}, '{2'b11, 2'b01, 2'b10},
             '{2'b01, 2'b01, 2'b00}};
      // Winner follows the not-most-recently-granted rule; feed 0 wins the first tie.
      rv = '{'{2'b11, 2'b01}, '{2'b11, 2'b10}, '{2'b10, 2'b10},
             '{2'b11, 2'b01}, '{2'b01, 2'b01}, '{2'b11, 2'b10}};

      bus.in_valid = 2'b00;  bus.in_startofpacket = 2'b00;  bus.in_endofpacket = 2'b00;
      bus.in_error = 2'b00;  bus.in_data = '0;  bus.in_empty = '0;  bus.out_ready = 1'b1;

      // Reset state, with non-sop beats offered to prove in_ready is held low.
      #1 reset_n = 1'b0;
      bus.in_valid = 2'b11;
      #11;
      check("rst_in_ready", bus.in_ready, 2'b00);
      check("rst_out_valid", bus.out_valid, 1'b0);
      check("rst_out_payload", out_beat(), '0);
      check("rst_grant", bus.grant, 2'b00);
      check("rst_drop_wdog", {bus.drop_pulse, bus.wdog_abort}, 2'b00);
      bus.in_valid = 2'b00;
      @(posedge clk);
      #1 reset_n = 1'b1;
      tick();
      tick();

      // IDLE in_ready vectors (combinational; inputs withdrawn before any edge).
      for (int i = 0; i < 7; i++) begin
         bus.in_valid = iv[i].valid;
         bus.in_startofpacket = iv[i].sop;
         #2;
         check($sformatf("idle_ready[%0d]", i), bus.in_ready, iv[i].exp_ready);
         bus.in_valid = 2'b00;
         bus.in_startofpacket = 2'b00;
         tick();
      end

      // Simultaneous sop on both feeds: feed 0 packet, one IDLE cycle, then feed 1 packet.
      push_pkt(3, 'h100, -1, -1);
      push_pkt(3, 'h200, -1, -1);
      grant_hist.delete();
      mark = cyc;
      first_ov_cyc = -1;
      run_feeds(3, 3, 'h100, 'h200, -1, -1, -1, -1);
      drain();
      check("grant_hist_len", 128'(grant_hist.size()), 128'(2));
      if (grant_hist.size() == 2) begin
         check("grant_first", grant_hist[0], 2'b01);
         check("grant_second", grant_hist[1], 2'b10);
      end
      check("sop_to_valid_latency", 128'(first_ov_cyc - mark - 1), 128'(2));
      check("eop_to_next_sop_gap", 128'(sop1_cyc - eop0_cyc), 128'(2));

      // Mid-packet sop flagged as error; in_error copied through.
      push_pkt(3, 'h300, 1, 2);
      run_feeds(3, 0, 'h300, '0, -1, -1, 1, 2);
      drain();

      // Output back-pressure for three cycles in the middle of a 4-beat packet.
      push_pkt(4, 'h400, -1, -1);
      run_feeds(4, 0, 'h400, '0, 2, 4, -1, -1);
      drain();

      // Non-sop beats in IDLE are swallowed with a drop pulse each.
      d0 = drop_cnt;
      o0 = ov_cnt;
      drive(1, 1'b1, 1'b0, 1'b0, 1'b0, 'h55, '0);
      tick();
      check("idle_drop_acc0", samp_acc, 2'b10);
      drive(1, 1'b1, 1'b0, 1'b1, 1'b0, 'h66, '0);
      tick();
      check("idle_drop_acc1", samp_acc, 2'b10);
      drive(1, 1'b0, 1'b0, 1'b0, 1'b0, '0, '0);
      tick();
      tick();
      check("idle_drop_count", 128'(drop_cnt - d0), 128'(2));
      check("idle_drop_no_output", 128'(ov_cnt - o0), 128'(0));
      check("idle_drop_grant", samp_grant, 2'b00);

      // Round-robin table from a fresh reset, single-beat packets.
      reset_n = 1'b0;
      tick();
      reset_n = 1'b1;
      tick();
      for (int i = 0; i < 6; i++) begin
         ab = '{data: W'('h500 + 16 * i + int'(rv[i].exp_grant == 2'b10)), empty: '0,
                sop: 1'b1, eop: 1'b1, err: 1'b0};
         exp_q.push_back(ab);
         for (int f = 0; f < 2; f++)
            drive(f, rv[i].req[f], 1'b1, 1'b1, 1'b0, W'('h500 + 16 * i + f), '0);
         got = 1'b0;
         for (int t = 0; t < 8 && !got; t++) begin
            tick();
            got = (samp_grant != 2'b00);
         end
         check($sformatf("rr_grant[%0d]", i), samp_grant, rv[i].exp_grant);
         drive(0, 1'b0, 1'b0, 1'b0, 1'b0, '0, '0);
         drive(1, 1'b0, 1'b0, 1'b0, 1'b0, '0, '0);
         drain();
      end

      // Feed 0 stalls after its first beat of three.
      d0 = drop_cnt;
      w0 = wdog_cnt;
      push_pkt(1, 'h700, -1, -1);
      exp_q[exp_q.size() - 1].eop = 1'b0;
`ifdef FEED_ARBITER_WDOG_EN
      ab = '{data: '0, empty: E'(BB - 1), sop: 1'b0, eop: 1'b1, err: 1'b1};
      exp_q.push_back(ab);
`endif
      send_one(0, 1'b1, 1'b0, 'h700, 3'd0);
      acc_cyc = cyc;
      drive(0, 1'b0, 1'b0, 1'b0, 1'b0, '0, '0);
      repeat (40) tick();
      check("stall_grant_held", samp_grant, 2'b01);
`ifdef FEED_ARBITER_WDOG_EN
      check("wdog_pulse_count", 128'(wdog_cnt - w0), 128'(1));
      check("wdog_timing", 128'(wdog_cyc - acc_cyc), 128'(17));
`else
      check("no_wdog_pulse", 128'(wdog_cnt - w0), 128'(0));
      ab = '{data: 'h701, empty: 3'd1, sop: 1'b0, eop: 1'b0, err: 1'b0};
      exp_q.push_back(ab);
      ab = '{data: 'h702, empty: 3'd2, sop: 1'b0, eop: 1'b1, err: 1'b0};
      exp_q.push_back(ab);
`endif
      send_one(0, 1'b0, 1'b0, 'h701, 3'd1);
      send_one(0, 1'b0, 1'b1, 'h702, 3'd2);
      drive(0, 1'b0, 1'b0, 1'b0, 1'b0, '0, '0);
      drain();
      tick();
      check("stall_end_grant", samp_grant, 2'b00);
`ifdef FEED_ARBITER_WDOG_EN
      check("flush_drop_count", 128'(drop_cnt - d0), 128'(2));
`else
      check("stall_no_drops", 128'(drop_cnt - d0), 128'(0));
`endif

      // Reset during beat 2 of a 5-beat packet: only beat 0 ever reaches the output.
      push_pkt(1, 'h800, -1, -1);
      exp_q[exp_q.size() - 1].eop = 1'b0;
      send_one(0, 1'b1, 1'b0, 'h800, 3'd0);
      drive(0, 1'b1, 1'b0, 1'b0, 1'b0, 'h801, 3'd1);
      tick();
      check("rst_mid_beat1_acc", samp_acc[0], 1'b1);
      drive(0, 1'b1, 1'b0, 1'b0, 1'b0, 'h802, 3'd2);
      reset_n = 1'b0;
      #2;
      check("rst_mid_out_valid", bus.out_valid, 1'b0);
      check("rst_mid_grant", bus.grant, 2'b00);
      check("rst_mid_in_ready", bus.in_ready, 2'b00);
      drive(0, 1'b0, 1'b0, 1'b0, 1'b0, '0, '0);
      tick();
      tick();
      reset_n = 1'b1;
      tick();
      check("rst_mid_scoreboard", 128'(exp_q.size()), 128'(0));
      push_pkt(5, 'h900, -1, -1);
      run_feeds(0, 5, '0, 'h900, -1, -1, -1, -1);
      drain();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   // Hard stop in case a wait escapes its own bound.
   initial begin
      #200000;
      $display("FAIL global_timeout: got running expected finished");
      $fatal(1, "timeout");
   end
endmodule
